// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of mem_port_arbiter; slave modport is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NUM_REQ-1:0]       i_req;
  logic [NUM_REQ-1:0]       i_lock;
  logic [NUM_REQ-1:0]       i_we;
  logic [NUM_REQ*AW-1:0]    i_addr;
  logic [NUM_REQ*WIDTH-1:0] i_wdata;
  logic [NUM_REQ-1:0]       o_gnt;
  logic [WIDTH-1:0]         o_rdata;
  logic [NUM_REQ-1:0]       o_rvalid;
  logic                     o_mem_we;
  logic [AW-1:0]            o_mem_addr;
  logic [WIDTH-1:0]         o_mem_wdata;
  logic [WIDTH-1:0]         i_mem_rdata;
  logic                     o_busy;

  modport slave (
    input  i_req, i_lock, i_we, i_addr, i_wdata, i_mem_rdata,
    output o_gnt, o_rdata, o_rvalid, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );

  modport master (
    output i_req, i_lock, i_we, i_addr, i_wdata, i_mem_rdata,
    input  o_gnt, o_rdata, o_rvalid, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered-read memory port, with burst lock and tagged read return.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(NUM_REQ);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state;
  logic [PW-1:0]      owner;
  logic               gnt_any;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               sel_we;
  logic               sel_lock;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_wdata;
  logic               tag1_v, tag2_v;
  logic [PW-1:0]      tag1_k, tag2_k;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (state == ST_LOCKED) begin
      if (bus.i_req[owner]) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && bus.i_req[PW'(i)]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cand;
  int unsigned   j;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
    return (32'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    j       = 0;
    if (state == ST_LOCKED) begin
      if (bus.i_req[owner]) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
      end
    end else begin
      // Scan from rr_ptr upward, wrapping at NUM_REQ (need not be a power of two).
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        j = 32'(rr_ptr) + i;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        cand = PW'(j);
        if (!gnt_any && bus.i_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (gnt_any && i_rst_n) gnt[gnt_idx] = 1'b1;
    sel_we    = bus.i_we[gnt_idx];
    sel_lock  = bus.i_lock[gnt_idx];
    sel_addr  = bus.i_addr[int'(gnt_idx)*AW +: AW];
    sel_wdata = bus.i_wdata[int'(gnt_idx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_ARB;
      owner <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        ST_ARB: begin
          if (gnt_any) begin
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr <= inc_wrap(gnt_idx);
`endif
            if (sel_lock) begin
              state <= ST_LOCKED;
              owner <= gnt_idx;
            end
          end
        end
        default: begin
          // Owner either finished its burst or went idle for a cycle.
          if (!gnt_any || !sel_lock) begin
            state <= ST_ARB;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr <= inc_wrap(owner);
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      tag1_v          <= 1'b0;
      tag1_k          <= '0;
      tag2_v          <= 1'b0;
      tag2_k          <= '0;
    end else begin
      bus.o_mem_we <= gnt_any & sel_we;
      if (gnt_any) begin
        bus.o_mem_addr  <= sel_addr;
        bus.o_mem_wdata <= sel_wdata;
      end
      tag1_v <= gnt_any & ~sel_we;
      tag1_k <= gnt_idx;
      tag2_v <= tag1_v;
      tag2_k <= tag1_k;
    end
  end

  always_comb begin
    bus.o_rvalid = '0;
    if (tag2_v) bus.o_rvalid[tag2_k] = 1'b1;
  end

  assign bus.o_gnt   = gnt;
  assign bus.o_rdata = bus.i_mem_rdata;
  assign bus.o_busy  = (state == ST_LOCKED) | tag1_v | tag2_v;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants, writes and reads; a monitor checks them.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .DEPTH(16)) bus ();

  mem_port_arbiter #(.NUM_REQ(4), .WIDTH(32), .DEPTH(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Memory model: registered read, write when we=1
  logic [31:0] mem [16];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      init_done <= 1'b1;
    end else begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      bus.i_mem_rdata <= mem[bus.o_mem_addr];
    end
  end

  typedef struct {
    int          cyc;
    logic [3:0]  mask;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t gnt_q[$];
  exp_t wr_q[$];
  exp_t rd_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  exp_t ge, we_e, re;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_gnt != 4'b0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", 64'(bus.o_gnt), 64'(0));
        else begin
          ge = gnt_q.pop_front();
          chk("gnt_mask", 64'(bus.o_gnt), 64'(ge.mask));
          chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
        end
      end
      if (bus.o_mem_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 64'(bus.o_mem_we), 64'(0));
        else begin
          we_e = wr_q.pop_front();
          chk("wr_addr", 64'(bus.o_mem_addr), 64'(we_e.addr));
          chk("wr_data", 64'(bus.o_mem_wdata), 64'(we_e.data));
          chk("wr_cycle", 64'(cyc), 64'(we_e.cyc));
        end
      end
      if (bus.o_rvalid != 4'b0) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'(bus.o_rvalid), 64'(0));
        else begin
          re = rd_q.pop_front();
          chk("rd_valid", 64'(bus.o_rvalid), 64'(re.mask));
          chk("rd_data", 64'(bus.o_rdata), 64'(re.data));
          chk("rd_cycle", 64'(cyc), 64'(re.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int k, input logic we, input logic [3:0] addr,
                         input logic [31:0] data, input logic lock);
    bus.i_we[k]            = we;
    bus.i_lock[k]          = lock;
    bus.i_addr[k*4 +: 4]   = addr;
    bus.i_wdata[k*32 +: 32] = data;
  endtask

  task automatic exp_gnt(input logic [3:0] m);
    gnt_q.push_back('{cyc: cyc, mask: m, addr: 4'h0, data: 32'h0});
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [31:0] d);
    wr_q.push_back('{cyc: cyc + 1, mask: 4'h0, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [3:0] m, input logic [31:0] d);
    rd_q.push_back('{cyc: cyc + 2, mask: m, addr: 4'h0, data: d});
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_we", 64'(bus.o_mem_we), 64'(0));
    chk("rst_mem_addr", 64'(bus.o_mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(bus.o_mem_wdata), 64'(0));
    chk("rst_rvalid", 64'(bus.o_rvalid), 64'(0));
    chk("rst_gnt", 64'(bus.o_gnt), 64'(0));
    chk("rst_busy", 64'(bus.o_busy), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = 4'hF;
    #1;
    check_reset_outputs();
    tick();
    check_reset_outputs();
    tick();
    bus.i_req = 4'h0;
    rst_n = 1'b1;
  endtask

  int k;
  int waited;

  initial begin
    bus.i_req   = '0;
    bus.i_lock  = '0;
    bus.i_we    = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    tick();
    do_reset();

    // Single write then read of address 3
    tick();
    set_req(0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0);
    bus.i_req = 4'b0001;
    exp_gnt(4'b0001);
    exp_wr(4'd3, 32'hDEAD_BEEF);
    tick();
    bus.i_req = 4'b0000;
    tick();
    set_req(0, 1'b0, 4'd3, 32'h0, 1'b0);
    bus.i_req = 4'b0001;
    exp_gnt(4'b0001);
    exp_rd(4'b0001, 32'hDEAD_BEEF);
    tick();
    bus.i_req = 4'b0000;
    idle(3);

    // Fairness: all four read continuously from rr_ptr=0
    do_reset();
    for (int r = 0; r < 4; r++) set_req(r, 1'b0, 4'(8 + r), 32'h0, 1'b0);
    bus.i_req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      k = i % 4;
      exp_gnt(4'(1 << k));
      exp_rd(4'(1 << k), 32'h1000_0008 + 32'(k));
      tick();
    end
    bus.i_req = 4'h0;
    idle(3);

    // Lock burst by r2 while r0/r1 wait; rr_ptr=3 then wraps to r0
    set_req(2, 1'b1, 4'd5, 32'hA5A5_0005, 1'b1);
    bus.i_req = 4'b0100;
    exp_gnt(4'b0100);
    exp_wr(4'd5, 32'hA5A5_0005);
    tick();
    set_req(2, 1'b1, 4'd6, 32'hA5A5_0006, 1'b1);
    set_req(0, 1'b0, 4'd5, 32'h0, 1'b0);
    set_req(1, 1'b0, 4'd7, 32'h0, 1'b0);
    bus.i_req = 4'b0111;
    exp_gnt(4'b0100);
    exp_wr(4'd6, 32'hA5A5_0006);
    chk("lock_busy", 64'(bus.o_busy), 64'(1));
    tick();
    set_req(2, 1'b1, 4'd7, 32'hA5A5_0007, 1'b0);
    exp_gnt(4'b0100);
    exp_wr(4'd7, 32'hA5A5_0007);
    tick();
    bus.i_req = 4'b0011;
    chk("unlock_busy", 64'(bus.o_busy), 64'(0));
    exp_gnt(4'b0001);
    exp_rd(4'b0001, 32'hA5A5_0005);
    tick();
    bus.i_req = 4'b0010;
    exp_gnt(4'b0010);
    exp_rd(4'b0010, 32'hA5A5_0007);
    tick();
    bus.i_req = 4'b0000;
    idle(3);

    // Idle cycles
    for (int i = 0; i < 5; i++) begin
      chk("idle_gnt", 64'(bus.o_gnt), 64'(0));
      chk("idle_mem_we", 64'(bus.o_mem_we), 64'(0));
      chk("idle_rvalid", 64'(bus.o_rvalid), 64'(0));
      tick();
    end

    // Reset while r1 read is in flight; rr_ptr was 2 beforehand
    set_req(1, 1'b0, 4'd9, 32'h0, 1'b0);
    bus.i_req = 4'b0010;
    exp_gnt(4'b0010);
    tick();
    do_reset();
    set_req(0, 1'b0, 4'd8, 32'h0, 1'b0);
    set_req(3, 1'b0, 4'd11, 32'h0, 1'b0);
    bus.i_req = 4'b1001;
    exp_gnt(4'b0001);
    exp_rd(4'b0001, 32'h1000_0008);
    tick();
    bus.i_req = 4'b1000;
    exp_gnt(4'b1000);
    exp_rd(4'b1000, 32'h1000_000B);
    tick();
    bus.i_req = 4'b0000;
    idle(3);

    // r0 and r3 request continuously
    bus.i_req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      k = 0;
`else
      k = (i % 2 == 1) ? 3 : 0;
`endif
      exp_gnt(4'(1 << k));
      exp_rd(4'(1 << k), 32'h1000_0008 + 32'(k));
      tick();
    end
    bus.i_req = 4'b0000;

    waited = 0;
    while ((gnt_q.size() + wr_q.size() + rd_q.size()) != 0 && waited < 20) begin
      tick();
      waited++;
    end
    chk("drain_pending", 64'(gnt_q.size() + wr_q.size() + rd_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port memory (registered read, 1-cycle read latency, write when we=1, read otherwise) between NUM_REQ requesters.
- Accepts one access per cycle and registers the memory command.
- Routes the read response back to the requester that issued it.
- Supports a lock that holds the port for one requester across a burst.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, data width.
- DEPTH, 16, memory depth; AW = $clog2(DEPTH).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  NUM_REQ  per-requester access request.
- i_lock  in  NUM_REQ  hold grant after this beat.
- i_we  in  NUM_REQ  1 = write, 0 = read.
- i_addr  in  NUM_REQ*AW  flattened addresses; requester k at [k*AW +: AW].
- i_wdata  in  NUM_REQ*WIDTH  flattened write data.
- o_gnt  out  NUM_REQ  one-hot accept, combinational, same cycle as i_req.
- o_rdata  out  WIDTH  read data, broadcast.
- o_rvalid  out  NUM_REQ  one-hot read-data qualifier.
- o_mem_we  out  1  registered memory write enable.
- o_mem_addr  out  AW  registered memory address.
- o_mem_wdata  out  WIDTH  registered memory write data.
- i_mem_rdata  in  WIDTH  memory read data.
- o_busy  out  1  high in LOCKED state or while any read is in flight.

Behaviour:
- Reset values: o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rvalid=0, state=ARB, rr_ptr=0, read tags cleared. o_gnt=0 while in reset.
- Handshake:
  - A beat transfers when i_req[k] & o_gnt[k].
  - The requester holds i_we, i_addr, i_wdata and i_lock stable until granted.
  - At most one o_gnt bit is set per cycle.
- Arbitration in state ARB:
  - Search i_req starting at rr_ptr, upward with wrap; grant the first set bit.
  - After granting k: rr_ptr = (k+1) mod NUM_REQ. rr_ptr is unchanged if nothing is granted.
- Command pipeline:
  - Grant in cycle T → o_mem_we/addr/wdata valid in cycle T+1, registered from the winner's inputs.
  - With no grant, o_mem_we=0 in T+1; addr/wdata hold their previous values (the idle read is harmless).
- Read return:
  - A granted read at T loads tag {valid, k} through a 2-stage tag pipeline.
  - At T+2: o_rvalid[k]=1 for exactly one cycle, and o_rdata = i_mem_rdata (combinational pass-through).
  - Writes produce no o_rvalid.
  - Back-to-back reads from different requesters return in order, one per cycle.
  - The memory's own valid signal is not used; the tag pipeline is authoritative.
- Write-then-read to the same address in consecutive grants returns the new data; the memory sequencing guarantees this and no bypass is required.
- Lock FSM:
  - ARB → LOCKED(owner=k) when k is granted with i_lock[k]=1.
  - LOCKED: only i_req[owner] can be granted; other requests wait with o_gnt=0.
  - LOCKED → ARB when the owner's granted beat has i_lock=0, or when i_req[owner]=0 for a cycle. On exit, rr_ptr = owner+1.
- Simultaneous requests: the round-robin order decides. A requester that drops i_req before its grant loses its slot with no side effects.
- Reset mid-operation: in-flight tags are discarded (no o_rvalid after reset), the lock is released, and the memory command is forced to we=0.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest index wins; rr_ptr is not implemented. Lock behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single write then read: r0 writes addr 3 = 0xDEADBEEF at T0 → o_mem_we=1, addr=3 at T1. r0 reads addr 3 at T2 → o_rvalid=4'b0001 and o_rdata=0xDEADBEEF at T4.
- Fairness: all 4 requesters hold reads continuously → grants rotate 0,1,2,3,0… one per cycle, o_rvalid follows 2 cycles later in the same order.
- Lock burst: r2 issues 3 writes to addr 5,6,7, with i_lock=1 on the first two and 0 on the third, while r0 and r1 request → r0/r1 are not granted until after the third beat, then r0 is granted next (rr_ptr=3 wraps to 0 because r3 is idle).
- Idle cycles: no requests for 5 cycles → o_mem_we=0, o_rvalid=0, o_gnt=0 throughout.
- Reset mid-read: r1 read granted at T0, i_rst_n low at T1 → no o_rvalid at T2, all outputs at reset values, state=ARB.
- With ARB_FIXED_PRIO_EN: r0 and r3 request continuously → r0 granted every cycle and r3 never granted.
